// File: rtl/pixel_serializer.sv
// Buffers shaded pixels in a small FIFO and streams each one out as R,G,B bytes
// (or two RGB565 bytes when PIXEL_SERIALIZER_RGB565_EN is defined).
module pixel_serializer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_sof,
  output logic       overflow,
  output logic [3:0] fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 25;
  localparam logic [3:0] FULL_LVL = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, BYTE2} state_e;

  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       level_q, level_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [ENT_W-1:0] hold_q, hold_d;

  logic             push;
  logic             pop;
  logic             accept;
  logic             last_byte;
  logic [ENT_W-1:0] in_entry;

  function automatic logic [7:0] pick_byte(input state_e st, input logic [23:0] rgb);
    logic [7:0] r, g, b;
    r = rgb[23:16];
    g = rgb[15:8];
    b = rgb[7:0];
`ifdef PIXEL_SERIALIZER_RGB565_EN
    case (st)
      BYTE0:   pick_byte = {r[7:3], g[7:5]};
      BYTE1:   pick_byte = {g[4:2], b[7:3]};
      default: pick_byte = 8'h00;
    endcase
`else
    case (st)
      BYTE0:   pick_byte = r;
      BYTE1:   pick_byte = g;
      BYTE2:   pick_byte = b;
      default: pick_byte = 8'h00;
    endcase
`endif
  endfunction

  // Input side: readiness comes only from the registered level, so a full FIFO
  // refuses a push even when a pop happens on the same edge.
  assign in_ready = rst_n && (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign in_entry = {(in_x == 10'd0) && (in_y == 10'd0), in_r, in_g, in_b};

  assign out_valid = (state_q != IDLE);
  assign accept    = out_valid && out_ready;
`ifdef PIXEL_SERIALIZER_RGB565_EN
  assign last_byte = (state_q == BYTE1);
`else
  assign last_byte = (state_q == BYTE2);
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    state_d = IDLE;
      BYTE0:   if (accept) state_d = BYTE1;
      BYTE1:   if (accept) state_d = BYTE2;
      BYTE2:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Loading the next pixel on the final byte's acceptance keeps the stream gapless.
    if ((state_q == IDLE) || (accept && last_byte)) begin
      if (level_q != 4'd0) begin
        pop     = 1'b1;
        hold_d  = fifo_mem_q[rd_ptr_q];
        state_d = BYTE0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || (in_valid && !in_ready);
    if (push) begin
      fifo_mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 4'd0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      hold_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
    end
  end

  // Storage is unreachable until written, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign out_data   = pick_byte(state_q, hold_q[23:0]);
  assign out_sop    = (state_q == BYTE0);
  assign out_sof    = out_sop && hold_q[24];
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule
